// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier with a full 2*WIDTH-bit product.
// Signed operands are handled as magnitudes, and the sign is applied once the last iteration completes.
module seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH:0]       upper_sum;
  logic [CNT_W-1:0]     cnt;
  logic                 neg, last, accept;

  // The most negative operand negates to 2^(WIDTH-1), which is still exact as an unsigned value.
  assign a_mag  = (is_signed & a[WIDTH-1]) ? -a : a;
  assign b_mag  = (is_signed & b[WIDTH-1]) ? -b : b;
  assign accept = in_valid & in_ready;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // The add into the upper half keeps its carry, and that carry moves into the top bit on the shift.
  assign upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_step  = {upper_sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (accept) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      prod   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mcand  <= a_mag;
          mplier <= b_mag;
          neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc    <= '0;
          cnt    <= '0;
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) prod <= neg ? -acc_step : acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=8, 16 and 2.
// Stimulus pushes the expected products, and per-instance monitors pop and compare them on each output handshake.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 0, ir8, s8 = 0, ov8, or8 = 1, busy8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;
  logic        iv16 = 0, ir16, s16 = 0, ov16, or16 = 1, busy16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;
  logic        iv2 = 0, ir2, s2 = 0, ov2, or2 = 1, busy2;
  logic [1:0]  a2 = 0, b2 = 0;
  logic [3:0]  p2;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .is_signed(s8),
    .out_valid(ov8), .out_ready(or8), .prod(p8), .busy(busy8));
  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .is_signed(s16),
    .out_valid(ov16), .out_ready(or16), .prod(p16), .busy(busy16));
  seq_multiplier #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .is_signed(s2),
    .out_valid(ov2), .out_ready(or2), .prod(p2), .busy(busy2));

  int n_chk = 0, n_fail = 0;
  logic [15:0] q8[$];
  logic [31:0] q16[$];
  logic [3:0]  q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, expected none", name);
  endtask

  // Monitors: one output handshake per negedge, with out_valid and out_ready both high
  always @(negedge clk) if (!rst && ov8 && or8) begin
    if (q8.size() == 0) flag("dut8 unexpected result");
    else check("dut8 prod", 32'(p8), 32'(q8.pop_front()));
  end
  always @(negedge clk) if (!rst && ov16 && or16) begin
    if (q16.size() == 0) flag("dut16 unexpected result");
    else check("dut16 prod", p16, q16.pop_front());
  end
  always @(negedge clk) if (!rst && ov2 && or2) begin
    if (q2.size() == 0) flag("dut2 unexpected result");
    else check("dut2 prod", 32'(p2), 32'(q2.pop_front()));
  end

  // Each issue task returns 1 time unit after the acceptance edge
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input bit push);
    int t = 0;
    @(posedge clk); #1;
    while (!ir8 && t < 200) begin @(posedge clk); #1; t++; end
    if (!ir8) begin flag("dut8 in_ready wait"); return; end
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    if (push) q8.push_back(exp);
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = ~a; b8 = ~b; s8 = ~s;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] exp);
    int t = 0;
    @(posedge clk); #1;
    while (!ir16 && t < 200) begin @(posedge clk); #1; t++; end
    if (!ir16) begin flag("dut16 in_ready wait"); return; end
    a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
    q16.push_back(exp);
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = ~a; b16 = ~b; s16 = ~s;
  endtask

  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic s,
                        input logic [3:0] exp);
    int t = 0;
    @(posedge clk); #1;
    while (!ir2 && t < 50) begin @(posedge clk); #1; t++; end
    if (!ir2) begin flag("dut2 in_ready wait"); return; end
    a2 = a; b2 = b; s2 = s; iv2 = 1'b1;
    q2.push_back(exp);
    @(posedge clk); #1;
    iv2 = 1'b0; a2 = ~a; b2 = ~b; s2 = ~s;
  endtask

  task automatic drain();
    int t = 0;
    while ((q8.size() + q16.size() + q2.size()) != 0 && t < 500) begin @(posedge clk); #1; t++; end
    if ((q8.size() + q16.size() + q2.size()) != 0) flag("drain pending results");
  endtask

  initial begin
    int k, seen;
    // Reset state
    @(negedge clk);
    check("reset in_ready", 32'(ir8), 32'd0);
    check("reset out_valid", 32'(ov8), 32'd0);
    check("reset busy", 32'(busy8), 32'd0);
    check("reset prod", 32'(p8), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 check("in_ready after reset", 32'(ir8), 32'd1);

    // Unsigned max, with latency and busy checks
    issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1);
    k = 0;
    while (!ov8 && k < 30) begin
      if (!busy8) flag("busy during CALC");
      @(posedge clk); #1; k++;
    end
    check("latency w8", 32'(k), 32'd8);
    check("busy in DONE", 32'(busy8), 32'd1);
    drain();

    // Signed corners
    issue8(8'h80, 8'h80, 1'b1, 16'h4000, 1);
    issue8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1);
    issue8(8'h7F, 8'h80, 1'b1, 16'hC080, 1);
    issue8(8'hF9, 8'h00, 1'b1, 16'h0000, 1);
    issue8(8'h00, 8'h80, 1'b1, 16'h0000, 1);
    drain();

    // Back-pressure
    or8 = 1'b0;
    issue8(8'h0F, 8'h11, 1'b0, 16'h00FF, 1);
    k = 0;
    while (!ov8 && k < 30) begin @(posedge clk); #1; k++; end
    if (!ov8) flag("backpressure out_valid wait");
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'b1; a8 = 8'h01; b8 = 8'h01; s8 = 1'b0;
      @(posedge clk); #1;
      check("bp out_valid held", 32'(ov8), 32'd1);
      check("bp prod held", 32'(p8), 32'h00FF);
      check("bp in_ready low", 32'(ir8), 32'd0);
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    check("bp out_valid cleared", 32'(ov8), 32'd0);
    check("bp in_ready back", 32'(ir8), 32'd1);
    check("bp queue drained", 32'(q8.size()), 32'd0);

    // Reset three edges into CALC
    issue8(8'h09, 8'h09, 1'b0, 16'h0051, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst out_valid", 32'(ov8), 32'd0);
    check("rst busy", 32'(busy8), 32'd0);
    check("rst prod", 32'(p8), 32'd0);
    check("rst in_ready", 32'(ir8), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (ov8) seen++;
      @(posedge clk); #1;
    end
    check("no out_valid after rst", 32'(seen), 32'd0);
    check("in_ready after rst", 32'(ir8), 32'd1);
    issue8(8'd12, 8'd10, 1'b0, 16'h0078, 1);
    drain();

    // Back-to-back
    issue8(8'd200, 8'd3, 1'b0, 16'h0258, 1);
    issue8(8'd100, 8'hFE, 1'b1, 16'hFF38, 1);
    drain();

    // WIDTH=16
    issue16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    k = 0;
    while (!ov16 && k < 40) begin @(posedge clk); #1; k++; end
    check("latency w16", 32'(k), 32'd16);
    issue16(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    issue16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
    drain();

    // WIDTH=2, all operand pairs in both modes
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++) begin
          int sx, sy;
          sx = (s == 1 && x >= 2) ? x - 4 : x;
          sy = (s == 1 && y >= 2) ? y - 4 : y;
          issue2(2'(x), 2'(y), 1'(s), 4'(sx * sy));
        end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
